// File: rtl/memory_bus_if.sv
// memory_bus_if: CPU bus write front end for the BRAMs.
// Turns each bus write into one strobe on CNT/MOD/PWE/STM.
//
// Ports:
//   BUS_CLK, RST (async, active high)
//   EN, WE, BRAM_SELECT[1:0], BRAM_ADDR[13:0], DATA_IN[15:0]
//   CNT_WE/ADDR[13:0]/DIN  controller RAM port
//   MOD_WE/ADDR[14:0]/DIN  mod RAM port, {seg, addr}
//   PWE_WE/ADDR[7:0]/DIN   PWE table port
//   STM_WE/ADDR[18:0]/DIN  STM RAM port, {seg, page, addr}
//   MOD_WR_SEGMENT, STM_WR_SEGMENT, STM_WR_PAGE[3:0]
//   STAT_WR_COUNT[3:0][15:0] with MEMORY_BUS_STATS_EN
//
// Optional feature macro: MEMORY_BUS_STATS_EN
module memory_bus_if #(
  parameter logic [1:0]  SEL_CONTROLLER      = 2'd0,
  parameter logic [1:0]  SEL_MOD             = 2'd1,
  parameter logic [1:0]  SEL_PWE_TABLE       = 2'd2,
  parameter logic [1:0]  SEL_STM             = 2'd3,
  parameter logic [13:0] ADDR_MOD_WR_SEGMENT = 14'h0020,
  parameter logic [13:0] ADDR_STM_WR_SEGMENT = 14'h0050,
  parameter logic [13:0] ADDR_STM_WR_PAGE    = 14'h0051
) (
  input  logic        BUS_CLK,
  input  logic        RST,
  input  logic        EN,
  input  logic        WE,
  input  logic [1:0]  BRAM_SELECT,
  input  logic [13:0] BRAM_ADDR,
  input  logic [15:0] DATA_IN,
  output logic        CNT_WE,
  output logic [13:0] CNT_ADDR,
  output logic [15:0] CNT_DIN,
  output logic        MOD_WE,
  output logic [14:0] MOD_ADDR,
  output logic [15:0] MOD_DIN,
  output logic        PWE_WE,
  output logic [7:0]  PWE_ADDR,
  output logic [15:0] PWE_DIN,
  output logic        STM_WE,
  output logic [18:0] STM_ADDR,
  output logic [15:0] STM_DIN,
  output logic        MOD_WR_SEGMENT,
  output logic        STM_WR_SEGMENT,
  output logic [3:0]  STM_WR_PAGE
`ifdef MEMORY_BUS_STATS_EN
  ,
  output logic [3:0][15:0] STAT_WR_COUNT
`endif
);

  logic        r_wr1;
  logic        r_wr2;
  logic [1:0]  r_sel;
  logic [13:0] r_addr;
  logic [15:0] r_din;
  logic        w_evt;

  // Edge stages reset to 1 so a write still held
  // across reset release never looks like a new edge.
  always_ff @(posedge BUS_CLK or posedge RST) begin
    if (RST) begin
      r_wr1  <= 1'b1;
      r_wr2  <= 1'b1;
      r_sel  <= 2'd0;
      r_addr <= 14'd0;
      r_din  <= 16'd0;
    end else begin
      r_wr1  <= EN & WE;
      r_wr2  <= r_wr1;
      r_sel  <= BRAM_SELECT;
      r_addr <= BRAM_ADDR;
      r_din  <= DATA_IN;
    end
  end

  assign w_evt = r_wr1 & ~r_wr2;

  always_ff @(posedge BUS_CLK or posedge RST) begin
    if (RST) begin
      CNT_WE         <= 1'b0;
      CNT_ADDR       <= 14'd0;
      CNT_DIN        <= 16'd0;
      MOD_WE         <= 1'b0;
      MOD_ADDR       <= 15'd0;
      MOD_DIN        <= 16'd0;
      PWE_WE         <= 1'b0;
      PWE_ADDR       <= 8'd0;
      PWE_DIN        <= 16'd0;
      STM_WE         <= 1'b0;
      STM_ADDR       <= 19'd0;
      STM_DIN        <= 16'd0;
      MOD_WR_SEGMENT <= 1'b0;
      STM_WR_SEGMENT <= 1'b0;
      STM_WR_PAGE    <= 4'd0;
    end else begin
      CNT_WE <= 1'b0;
      MOD_WE <= 1'b0;
      PWE_WE <= 1'b0;
      STM_WE <= 1'b0;
      if (w_evt) begin
        case (r_sel)
          SEL_CONTROLLER: begin
            CNT_WE   <= 1'b1;
            CNT_ADDR <= r_addr;
            CNT_DIN  <= r_din;
            // segment/page shadows take effect
            // on the next mod/STM write
            if (r_addr == ADDR_MOD_WR_SEGMENT)
              MOD_WR_SEGMENT <= r_din[0];
            if (r_addr == ADDR_STM_WR_SEGMENT)
              STM_WR_SEGMENT <= r_din[0];
            if (r_addr == ADDR_STM_WR_PAGE)
              STM_WR_PAGE <= r_din[3:0];
          end
          SEL_MOD: begin
            MOD_WE   <= 1'b1;
            MOD_ADDR <= {MOD_WR_SEGMENT, r_addr};
            MOD_DIN  <= r_din;
          end
          SEL_PWE_TABLE: begin
            PWE_WE   <= 1'b1;
            PWE_ADDR <= r_addr[7:0];
            PWE_DIN  <= r_din;
          end
          SEL_STM: begin
            STM_WE   <= 1'b1;
            STM_ADDR <= {STM_WR_SEGMENT,
                         STM_WR_PAGE, r_addr};
            STM_DIN  <= r_din;
          end
          default: ;
        endcase
      end
    end
  end

`ifdef MEMORY_BUS_STATS_EN
  logic [3:0] w_stb;
  assign w_stb = {STM_WE, PWE_WE, MOD_WE, CNT_WE};

  always_ff @(posedge BUS_CLK or posedge RST) begin
    if (RST) begin
      STAT_WR_COUNT <= '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (w_stb[i] && STAT_WR_COUNT[i] != 16'hFFFF)
          STAT_WR_COUNT[i] <= STAT_WR_COUNT[i] + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_memory_bus_if.sv
// tb_memory_bus_if: directed bench for memory_bus_if.
// Transaction-level model plus per-cycle compare.
module tb_memory_bus_if;

  logic        BUS_CLK = 1'b0;
  logic        RST;
  logic        EN;
  logic        WE;
  logic [1:0]  BRAM_SELECT;
  logic [13:0] BRAM_ADDR;
  logic [15:0] DATA_IN;
  logic        CNT_WE;
  logic [13:0] CNT_ADDR;
  logic [15:0] CNT_DIN;
  logic        MOD_WE;
  logic [14:0] MOD_ADDR;
  logic [15:0] MOD_DIN;
  logic        PWE_WE;
  logic [7:0]  PWE_ADDR;
  logic [15:0] PWE_DIN;
  logic        STM_WE;
  logic [18:0] STM_ADDR;
  logic [15:0] STM_DIN;
  logic        MOD_WR_SEGMENT;
  logic        STM_WR_SEGMENT;
  logic [3:0]  STM_WR_PAGE;
`ifdef MEMORY_BUS_STATS_EN
  logic [3:0][15:0] STAT_WR_COUNT;
`endif

  memory_bus_if dut (
    .BUS_CLK(BUS_CLK), .RST(RST),
    .EN(EN), .WE(WE),
    .BRAM_SELECT(BRAM_SELECT),
    .BRAM_ADDR(BRAM_ADDR),
    .DATA_IN(DATA_IN),
    .CNT_WE(CNT_WE), .CNT_ADDR(CNT_ADDR),
    .CNT_DIN(CNT_DIN),
    .MOD_WE(MOD_WE), .MOD_ADDR(MOD_ADDR),
    .MOD_DIN(MOD_DIN),
    .PWE_WE(PWE_WE), .PWE_ADDR(PWE_ADDR),
    .PWE_DIN(PWE_DIN),
    .STM_WE(STM_WE), .STM_ADDR(STM_ADDR),
    .STM_DIN(STM_DIN),
    .MOD_WR_SEGMENT(MOD_WR_SEGMENT),
    .STM_WR_SEGMENT(STM_WR_SEGMENT),
    .STM_WR_PAGE(STM_WR_PAGE)
`ifdef MEMORY_BUS_STATS_EN
    , .STAT_WR_COUNT(STAT_WR_COUNT)
`endif
  );

  always #5 BUS_CLK = ~BUS_CLK;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h",
               nm, act, exp);
    end
  endtask

  // one queued bus write, due on cycle 'due'
  typedef struct {
    int          due;
    logic [1:0]  sel;
    logic [13:0] addr;
    logic [15:0] data;
  } txn_t;

  txn_t q[$];
  int   cyc  = 0;
  logic prev = 1'b1;

  // model of what the sinks must see
  logic [13:0] m_cnt_a;
  logic [15:0] m_cnt_d;
  logic [14:0] m_mod_a;
  logic [15:0] m_mod_d;
  logic [7:0]  m_pwe_a;
  logic [15:0] m_pwe_d;
  logic [18:0] m_stm_a;
  logic [15:0] m_stm_d;
  logic        m_mseg;
  logic        m_sseg;
  logic [3:0]  m_page;

  // a bus write starts when the sampled EN&WE goes
  // high; its strobe is due one cycle later
  always @(posedge BUS_CLK) begin
    cyc++;
    if (RST) begin
      prev = 1'b1;
      q.delete();
    end else begin
      if (EN && WE && !prev)
        q.push_back('{cyc + 1, BRAM_SELECT,
                      BRAM_ADDR, DATA_IN});
      prev = EN & WE;
    end
  end

  always @(negedge BUS_CLK) begin : cmp
    logic [3:0] ew;
    txn_t t;
    ew = 4'b0000;
    if (RST) begin
      q.delete();
      m_cnt_a = '0; m_cnt_d = '0;
      m_mod_a = '0; m_mod_d = '0;
      m_pwe_a = '0; m_pwe_d = '0;
      m_stm_a = '0; m_stm_d = '0;
      m_mseg = 1'b0; m_sseg = 1'b0;
      m_page = 4'd0;
    end else if (q.size() > 0 &&
                 q[0].due == cyc) begin
      t = q.pop_front();
      case (t.sel)
        2'd0: begin
          ew[0] = 1'b1;
          m_cnt_a = t.addr;
          m_cnt_d = t.data;
          if (t.addr == 14'h0020)
            m_mseg = t.data[0];
          if (t.addr == 14'h0050)
            m_sseg = t.data[0];
          if (t.addr == 14'h0051)
            m_page = t.data[3:0];
        end
        2'd1: begin
          ew[1] = 1'b1;
          m_mod_a = 15'(m_mseg) * 15'h4000
                  + 15'(t.addr);
          m_mod_d = t.data;
        end
        2'd2: begin
          ew[2] = 1'b1;
          m_pwe_a = t.addr[7:0];
          m_pwe_d = t.data;
        end
        default: begin
          ew[3] = 1'b1;
          m_stm_a = 19'(m_sseg) * 19'h40000
                  + 19'(m_page) * 19'h4000
                  + 19'(t.addr);
          m_stm_d = t.data;
        end
      endcase
    end
    chk("we_vec",
        32'({STM_WE, PWE_WE, MOD_WE, CNT_WE}),
        32'(ew));
    chk("cnt_addr", 32'(CNT_ADDR), 32'(m_cnt_a));
    chk("cnt_din", 32'(CNT_DIN), 32'(m_cnt_d));
    chk("mod_addr", 32'(MOD_ADDR), 32'(m_mod_a));
    chk("mod_din", 32'(MOD_DIN), 32'(m_mod_d));
    chk("pwe_addr", 32'(PWE_ADDR), 32'(m_pwe_a));
    chk("pwe_din", 32'(PWE_DIN), 32'(m_pwe_d));
    chk("stm_addr", 32'(STM_ADDR), 32'(m_stm_a));
    chk("stm_din", 32'(STM_DIN), 32'(m_stm_d));
    chk("seg_page",
        32'({MOD_WR_SEGMENT, STM_WR_SEGMENT,
             STM_WR_PAGE}),
        32'({m_mseg, m_sseg, m_page}));
  end

  int pwe_pulses = 0;
  always @(negedge BUS_CLK)
    if (PWE_WE === 1'b1) pwe_pulses++;

  // drive a write; return when its strobe is visible
  task automatic wr_begin(input logic [1:0] s,
                          input logic [13:0] a,
                          input logic [15:0] d);
    EN = 1'b1; WE = 1'b1;
    BRAM_SELECT = s; BRAM_ADDR = a; DATA_IN = d;
    @(negedge BUS_CLK);
    @(negedge BUS_CLK);
    #1;
  endtask

  task automatic wr_end(input int extra);
    repeat (extra) @(negedge BUS_CLK);
    EN = 1'b0; WE = 1'b0;
    @(negedge BUS_CLK);
    @(negedge BUS_CLK);
  endtask

  task automatic wr(input logic [1:0] s,
                    input logic [13:0] a,
                    input logic [15:0] d);
    wr_begin(s, a, d);
    wr_end(0);
  endtask

  int p0;

  initial begin
    // 1: WE held through reset release
    RST = 1'b1; EN = 1'b1; WE = 1'b1;
    BRAM_SELECT = 2'd0;
    BRAM_ADDR = 14'h0011; DATA_IN = 16'h5555;
    repeat (3) @(negedge BUS_CLK);
    #2 RST = 1'b0;
    repeat (4) @(negedge BUS_CLK);
    #1;
    chk("t1_cnt_we", 32'(CNT_WE), 32'd0);
    chk("t1_cnt_addr", 32'(CNT_ADDR), 32'd0);
    wr_end(0);

    // 2: plain controller write
    wr_begin(2'd0, 14'h0123, 16'hBEEF);
    chk("t2_cnt_we", 32'(CNT_WE), 32'd1);
    chk("t2_cnt_addr", 32'(CNT_ADDR), 32'h0123);
    chk("t2_cnt_din", 32'(CNT_DIN), 32'hBEEF);
    wr_end(0);

    // 3: mod segment then mod write
    wr_begin(2'd0, 14'h0020, 16'h0001);
    chk("t3_mseg", 32'(MOD_WR_SEGMENT), 32'd1);
    wr_end(0);
    wr_begin(2'd1, 14'h0005, 16'h1234);
    chk("t3_mod_we", 32'(MOD_WE), 32'd1);
    chk("t3_mod_addr", 32'(MOD_ADDR), 32'h4005);
    chk("t3_mod_din", 32'(MOD_DIN), 32'h1234);
    wr_end(0);

    // 4: STM segment, page, STM write
    wr(2'd0, 14'h0050, 16'h0001);
    wr(2'd0, 14'h0051, 16'h0003);
    wr_begin(2'd3, 14'h0040, 16'hCAFE);
    chk("t4_stm_addr", 32'(STM_ADDR), 32'h4C040);
    chk("t4_page", 32'(STM_WR_PAGE), 32'd3);
    wr_end(0);

    // 5: PWE write, WE held 5 cycles, inputs wander
    p0 = pwe_pulses;
    wr_begin(2'd2, 14'h007F, 16'hFF00);
    chk("t5_pwe_addr", 32'(PWE_ADDR), 32'h7F);
    chk("t5_pwe_din", 32'(PWE_DIN), 32'hFF00);
    BRAM_ADDR = 14'h0055; DATA_IN = 16'h0F0F;
    BRAM_SELECT = 2'd0;
    wr_end(3);
    chk("t5_pulses", 32'(pwe_pulses - p0), 32'd1);
    chk("t5_pwe_hold", 32'(PWE_ADDR), 32'h7F);
    chk("t5_cnt_hold", 32'(CNT_ADDR), 32'h0051);

    // page uses low 4 bits; top-corner addresses
    wr(2'd0, 14'h0051, 16'h001F);
    wr_begin(2'd3, 14'h3FFF, 16'h0001);
    chk("pg_stm_addr", 32'(STM_ADDR), 32'h7FFFF);
    wr_end(0);
    wr(2'd0, 14'h0020, 16'h0002);
    wr_begin(2'd1, 14'h3FFF, 16'hA5A5);
    chk("seg0_mod_addr", 32'(MOD_ADDR), 32'h3FFF);
    wr_end(0);

    // 6a: WE without EN
    EN = 1'b0; WE = 1'b1;
    BRAM_SELECT = 2'd1; BRAM_ADDR = 14'h0009;
    repeat (3) @(negedge BUS_CLK);
    #1;
    chk("t6_noen_mod", 32'(MOD_WE), 32'd0);
    chk("t6_noen_addr", 32'(MOD_ADDR), 32'h3FFF);
    WE = 1'b0;
    @(negedge BUS_CLK);

    // 6b: reset between WE seen and strobe
    EN = 1'b1; WE = 1'b1;
    BRAM_SELECT = 2'd0; BRAM_ADDR = 14'h0050;
    DATA_IN = 16'h0001;
    @(negedge BUS_CLK);
    #2 RST = 1'b1;
    #1;
    chk("t6_rst_we", 32'(CNT_WE), 32'd0);
    chk("t6_rst_addr", 32'(CNT_ADDR), 32'd0);
    @(negedge BUS_CLK);
    EN = 1'b0; WE = 1'b0;
    @(negedge BUS_CLK);
    #2 RST = 1'b0;
    repeat (3) @(negedge BUS_CLK);
    #1;
    chk("t6_post_we", 32'(CNT_WE), 32'd0);
    chk("t6_post_sseg", 32'(STM_WR_SEGMENT), 32'd0);

    // a fresh write still works after reset
    wr_begin(2'd2, 14'h0001, 16'h0042);
    chk("t6_after_pwe", 32'(PWE_ADDR), 32'h01);
    wr_end(0);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
